// File: rtl/j1_io_pkg.sv
// Shared J1 I/O map: UART register addresses, status-word bit positions
// and the receive-ingest state encoding.
package j1_io_pkg;

    localparam logic [15:0] UART_RX_ADDR   = 16'h4000;
    localparam logic [15:0] UART_TX_ADDR   = 16'h4001;
    localparam logic [15:0] UART_STAT_ADDR = 16'h4002;

    localparam int STAT_AVAIL     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVF       = 2;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } ingest_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; head is readable combinationally.
// A pop on a full FIFO frees the slot for a push in the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_FULL);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Drains buart received bytes into a FIFO for the J1 CPU; provides the data
// and status registers on the I/O bus and a level interrupt while data waits.
module uart_rx_fifo
    import j1_io_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [15:0] DATA_ADDR = UART_RX_ADDR,
    parameter logic [15:0] STAT_ADDR = UART_STAT_ADDR
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_rd,
    input  logic        io_rd,
    input  logic [15:0] io_addr,
    output logic [15:0] io_din,
    output logic        rx_irq
);

    localparam int AW = $clog2(DEPTH);

    ingest_state_t r_state;
    logic          r_ovf;
    logic [7:0]    w_head;
    logic          w_full;
    logic          w_empty;
    logic [AW:0]   w_count;
    logic          w_pop;
    logic          w_stat_rd;
    logic          w_ovf_evt;
    logic [15:0]   w_stat;

    // Gated by resetq so the acknowledge is held low for the whole reset,
    // leaving any pending buart byte to be taken after release.
    assign rx_rd     = resetq && (r_state == ST_IDLE) && rx_valid;
    assign w_pop     = io_rd && (io_addr == DATA_ADDR) && !w_empty;
    assign w_stat_rd = io_rd && (io_addr == STAT_ADDR);
    assign w_ovf_evt = rx_rd && w_full && !w_pop;
    assign rx_irq    = !w_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetq  (resetq),
        .i_push  (rx_rd),
        .i_data  (rx_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // HOLD spends one cycle ignoring rx_valid while buart clears it.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (rx_valid) r_state <= ST_HOLD;
                ST_HOLD: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_evt) begin
            r_ovf <= 1'b1;
        end else if (w_stat_rd) begin
            r_ovf <= 1'b0;
        end
    end

    always_comb begin
        w_stat                             = '0;
        w_stat[STAT_AVAIL]                 = !w_empty;
        w_stat[STAT_FULL]                  = w_full;
        w_stat[STAT_OVF]                   = r_ovf;
        w_stat[STAT_COUNT_LSB +: AW+1]     = w_count;
    end

    always_comb begin
        io_din = '0;
        if (io_addr == DATA_ADDR) begin
            if (!w_empty) begin
                io_din = {8'h00, w_head};
            end
        end else if (io_addr == STAT_ADDR) begin
            io_din = w_stat;
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer between the `buart` receiver and the J1 I/O bus. It drains each received byte out of the UART's single holding register into a small synchronous FIFO. The CPU can then read bytes at its own pace, without overruns during bursts. It also exposes a memory-mapped status word and a level interrupt request that feeds the J1 `interrupt_request` input.

## Interface
Parameters:
- `DEPTH`, 16, number of FIFO entries; must be a power of two, ≥2.
- `DATA_ADDR`, 16'h4000, I/O address that reads and pops the head byte.
- `STAT_ADDR`, 16'h4002, I/O address that reads the status word.

Ports:
- `clk` in 1: single system clock; everything is synchronous to its rising edge.
- `resetq` in 1: reset, asynchronous, active-low.
- `rx_valid` in 1: buart has a received byte; stays high until acknowledged.
- `rx_data` in 8: buart received byte; stable while `rx_valid`=1.
- `rx_rd` out 1: one-cycle acknowledge to buart `rd`; buart drops `rx_valid` at the following edge.
- `io_rd` in 1: J1 I/O read strobe.
- `io_addr` in 16: J1 I/O address.
- `io_din` out 16: read data to J1; combinational from `io_addr` and FIFO state.
- `rx_irq` out 1: high while the FIFO is non-empty.

## Operation
- Ingest FSM has two states.
  - `IDLE`: if `rx_valid`, assert `rx_rd` combinationally this cycle and push `rx_data` at the edge. Go to `HOLD`.
  - `HOLD`: `rx_rd`=0 and `rx_valid` is ignored, covering buart's one-cycle clear latency. Return to `IDLE` unconditionally.
- Push when full and no pop in the same cycle:
  - Still acknowledge the byte (`rx_rd`=1) so buart never overruns internally.
  - Drop the byte.
  - Set sticky `ovf`.
- Pop on a clock edge when `io_rd`=1, `io_addr`=`DATA_ADDR` and the FIFO is non-empty.
- Push and pop in the same cycle: both take effect and `count` is unchanged. This also applies when full: the push is accepted and `ovf` is not set.
- `io_din` by address:
  - `DATA_ADDR`: `{8'h00, head}` if non-empty; 16'h0000 if empty, with no pop and no error.
  - `STAT_ADDR`: bit0 = non-empty, bit1 = full, bit2 = `ovf`, bits[15:8] = `count`, all other bits 0.
  - Any other address: 16'h0000.
- A read of `STAT_ADDR` with `io_rd`=1 clears `ovf` at that edge. The returned value shows `ovf` before the clear. If an overflow occurs in the same cycle, `ovf` stays set.
- Pointers are log2(DEPTH) bits wide and wrap naturally. `count` is log2(DEPTH)+1 bits wide, zero-extended into bits[15:8], and ranges 0..DEPTH.

## Timing
- Reset values: `rx_rd`=0, `rx_irq`=0, FSM=`IDLE`, pointers=0, `count`=0, `ovf`=0.
  - `io_din`=0 for every address except `STAT_ADDR`.
  - At `STAT_ADDR`, `io_din`=16'h0000 except bit1, which reads 1 only when DEPTH=0 (not permitted).
- Latency: `rx_valid` high in `IDLE` at cycle N → `rx_rd`=1 in cycle N → byte visible on `io_din`/`rx_irq` from cycle N+1.
- Throughput: one byte per 2 cycles on ingest; one pop per cycle on the CPU side.
- Reset mid-operation, including in `HOLD`: the FIFO empties and `ovf` clears.
  - If buart still holds a byte, it is taken on the first `IDLE` cycle after `resetq` deasserts.
- `rx_irq` is derived from registered state only; no combinational path from `io_*`.

## Structure
- Shared package `j1_io_pkg` holds:
  - `UART_RX_ADDR` = 16'h4000, `UART_TX_ADDR` = 16'h4001, `UART_STAT_ADDR` = 16'h4002.
  - Status bit indices: `STAT_AVAIL` = 0, `STAT_FULL` = 1, `STAT_OVF` = 2, `STAT_COUNT_LSB` = 8.
  - Ingest FSM state encoding.
- One sub-module, `sync_fifo`, parameterised by `WIDTH` and `DEPTH`:
  - Inputs/outputs: push/pop, full/empty, count.
  - Head data is available combinationally (first-word fall-through).
- The wrapper contains the ingest FSM, the overflow flag and address decode.

## Test plan
1. Reset, then drive `rx_valid`=1 with `rx_data`=8'h41 → `rx_rd` pulses exactly one cycle.
   - Next cycle: `STAT_ADDR` reads 16'h0101 and `rx_irq`=1.
   - A `DATA_ADDR` read returns 16'h0041; after the pop, status reads 16'h0000 and `rx_irq`=0.
2. Push 8'h00..8'h0F (DEPTH=16) with no reads → status reads 16'h1003.
   - 16 pops return 8'h00..8'h0F in order, and the pointers wrap.
   - Then push 8'hA5 → it is read back correctly.
3. Fill the FIFO, then send 8'hEE → `rx_rd` still pulses and the status reads 16'h1007.
   - The status read clears `ovf`; the next status read returns 16'h1003.
   - The FIFO contents are unchanged (8'hEE is dropped).
4. Full FIFO, with a pop of `DATA_ADDR` in the same cycle as a push of 8'h77 → `count` stays 16 and `ovf`=0.
   - 8'h77 is the last byte drained.
5. Read `DATA_ADDR` with the FIFO empty → `io_din`=16'h0000; `count` and pointers are unchanged.
   - An unmapped address (16'h4003) reads 16'h0000.
6. Deassert `resetq` while in `HOLD` with 3 bytes queued → all outputs return to their reset values immediately, asynchronously.
   - After release, a held buart byte 8'h5A is acknowledged and becomes the only entry.
